// File: rtl/init_reg_seq.sv
// Power-up register initialization sequencer: replays a static {addr,data} table
// as APB write transfers, then reports completion and the first failing entry.
module init_reg_seq #(
  parameter int N_INIT_REG  = 9,
  parameter int START_DELAY = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                                 i_apb_clk,
  input  logic                                                 i_apb_rst,
  input  logic [64*((N_INIT_REG > 0) ? N_INIT_REG : 1)-1:0]    i_init_reg,
  input  logic                                                 i_start,
  input  logic                                                 i_restart,
  output logic                                                 o_apb_psel,
  output logic                                                 o_apb_penable,
  output logic                                                 o_apb_pwrite,
  output logic [31:0]                                          o_apb_paddr,
  output logic [31:0]                                          o_apb_pwdata,
  input  logic                                                 i_apb_pready,
  input  logic                                                 i_apb_pslverr,
  output logic                                                 o_busy,
  output logic                                                 o_init_done,
  output logic                                                 o_init_err,
  output logic [7:0]                                           o_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam int TBL_N = (N_INIT_REG > 0) ? N_INIT_REG : 1;
  localparam int IDX_W = (TBL_N > 1) ? $clog2(TBL_N) : 1;
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TBL_N - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // Where a start or restart lands: an empty table finishes at once, no delay skips WAIT.
  localparam state_t START_STATE = (N_INIT_REG == 0)  ? S_DONE  :
                                   (START_DELAY == 0) ? S_SETUP : S_WAIT;

  logic [31:0] tbl_addr [TBL_N];
  logic [31:0] tbl_data [TBL_N];

  genvar gi;
  generate
    for (gi = 0; gi < TBL_N; gi++) begin : g_tbl
      assign tbl_addr[gi] = i_init_reg[64*gi+32 +: 32];
      assign tbl_data[gi] = i_init_reg[64*gi +: 32];
    end
  endgenerate

  state_t           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [DLY_W-1:0] dly_q,     dly_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic             err_q,     err_d;
  logic [7:0]       err_idx_q, err_idx_d;
  logic [31:0]      addr_q,    addr_d;
  logic [31:0]      wdata_q,   wdata_d;
  logic             psel_q,    psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q,  pwrite_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dly_d     = dly_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          idx_d   = '0;
          dly_d   = '0;
          state_d = START_STATE;
        end
      end
      S_WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = S_SETUP;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_SETUP: begin
        tmo_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A timeout aborts the transfer but the sequence always moves on.
        if (i_apb_pready || (tmo_q == TMO_LAST)) begin
          if ((!i_apb_pready || i_apb_pslverr) && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = 8'(idx_q);
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        if (i_restart) begin
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          dly_d     = '0;
          state_d   = START_STATE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // SETUP lasts one cycle, so entering it is the only time the bus payload changes.
    if (state_d == S_SETUP) begin
      addr_d  = tbl_addr[idx_d];
      wdata_d = tbl_data[idx_d];
    end

    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    pwrite_d  = psel_d;
    busy_d    = (state_d == S_WAIT) || psel_d;
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge i_apb_clk or posedge i_apb_rst) begin
    if (i_apb_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      dly_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_apb_psel    = psel_q;
  assign o_apb_penable = penable_q;
  assign o_apb_pwrite  = pwrite_q;
  assign o_apb_paddr   = addr_q;
  assign o_apb_pwdata  = wdata_q;
  assign o_busy        = busy_q;
  assign o_init_done   = done_q;
  assign o_init_err    = err_q;
  assign o_err_idx     = err_idx_q;

endmodule
